// File: rtl/pong_game_ctrl_pkg.sv
// Shared types and constants for the Pong game sequencer and its serve-angle generator.
package pong_game_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SERVE = 3'd1,
    ST_PLAY  = 3'd2,
    ST_POINT = 3'd3,
    ST_OVER  = 3'd4
  } state_t;

  // Screen centre the ball is reloaded to on every serve.
  localparam int CENTRE_X  = 31;
  localparam int CENTRE_Y  = 31;
  localparam int ANGLE_MAX = 45;
  localparam int ANGLE_MIN = -45;

endpackage

// File: rtl/pong_game_ctrl_if.sv
// Game-control bus between the frame/collision logic (master) and the sequencer (slave).
interface pong_game_ctrl_if #(
  parameter int SCORE_W = 4,
  parameter int ANGLE_W = 7
);

  logic                      start;
  logic                      frame_tick;
  logic                      miss_left;
  logic                      miss_right;
  logic                      ball_load;
  logic                      ball_en;
  logic signed [ANGLE_W-1:0] theta_o;
  logic                      serve_dir;
  logic        [SCORE_W-1:0] score_l;
  logic        [SCORE_W-1:0] score_r;
  logic                      game_over;
  logic        [2:0]         state_o;

  modport master (
    output start, frame_tick, miss_left, miss_right,
    input  ball_load, ball_en, theta_o, serve_dir, score_l, score_r, game_over, state_o
  );

  modport slave (
    input  start, frame_tick, miss_left, miss_right,
    output ball_load, ball_en, theta_o, serve_dir, score_l, score_r, game_over, state_o
  );

endinterface

// File: rtl/pong_game_ctrl_serve_lfsr.sv
// Free-running 16-bit Fibonacci LFSR (taps 16,14,13,11) mapped to a non-zero serve angle in [-45,+45].
module serve_lfsr
  import pong_game_ctrl_pkg::*;
#(
  parameter int          ANGLE_W   = 7,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      load,
  output logic signed [ANGLE_W-1:0] theta
);

  logic [15:0] lfsr;
  logic        fb;

  // Magnitudes 46..63 fold down by 32 so the distribution stays inside the angle limit.
  function automatic logic signed [ANGLE_W-1:0] angle_map(input logic [6:0] bits);
    logic        [5:0]         mag;
    logic signed [ANGLE_W-1:0] s;
    mag = bits[5:0];
    if (mag > 6'(ANGLE_MAX)) mag = mag - 6'd32;
    if (mag == 6'd0)         mag = 6'd1;
    s = ANGLE_W'(mag);
    return bits[6] ? -s : s;
  endfunction

  assign fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lfsr  <= LFSR_SEED;
      theta <= ANGLE_W'(1);
    end else begin
      lfsr <= {lfsr[14:0], fb};
      if (load) theta <= angle_map(lfsr[6:0]);
    end
  end

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong match sequencer: serve, play, point pause and match end, with both score counters.
module pong_game_ctrl
  import pong_game_ctrl_pkg::*;
#(
  parameter int          SCORE_W      = 4,
  parameter int          WIN_SCORE    = 11,
  parameter int          PAUSE_FRAMES = 60,
  parameter int          ANGLE_W      = 7,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic                  clk,
  input  logic                  reset,
  pong_game_ctrl_if.slave       bus
);

  localparam int                 CNT_W    = $clog2(PAUSE_FRAMES + 1);
  localparam logic [CNT_W-1:0]   CNT_LOAD = CNT_W'(PAUSE_FRAMES - 1);
  localparam logic [SCORE_W-1:0] WIN      = SCORE_W'(WIN_SCORE);

  state_t             state_q, state_d;
  logic [SCORE_W-1:0] score_l_q, score_l_d;
  logic [SCORE_W-1:0] score_r_q, score_r_d;
  logic               dir_q, dir_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic signed [ANGLE_W-1:0] theta;
  logic               serve_entry;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      score_l_q <= '0;
      score_r_q <= '0;
      dir_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      score_l_q <= score_l_d;
      score_r_q <= score_r_d;
      dir_q     <= dir_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    score_l_d = score_l_q;
    score_r_d = score_r_q;
    dir_d     = dir_q;
    cnt_d     = cnt_q;
    unique case (state_q)
      ST_IDLE, ST_OVER: begin
        if (bus.start) begin
          score_l_d = '0;
          score_r_d = '0;
          state_d   = ST_SERVE;
        end
      end
      ST_SERVE: state_d = ST_PLAY;
      ST_PLAY: begin
        // A simultaneous miss on both edges is a let: nobody scores, the server swaps.
        if (bus.miss_left && bus.miss_right) begin
          dir_d   = ~dir_q;
          cnt_d   = CNT_LOAD;
          state_d = ST_POINT;
        end else if (bus.miss_right) begin
          score_l_d = score_l_q + 1'b1;
          dir_d     = 1'b1;
          cnt_d     = CNT_LOAD;
          state_d   = (score_l_d == WIN) ? ST_OVER : ST_POINT;
        end else if (bus.miss_left) begin
          score_r_d = score_r_q + 1'b1;
          dir_d     = 1'b0;
          cnt_d     = CNT_LOAD;
          state_d   = (score_r_d == WIN) ? ST_OVER : ST_POINT;
        end
      end
      ST_POINT: begin
        if (bus.frame_tick) begin
          if (cnt_q == '0) state_d = ST_SERVE;
          else             cnt_d   = cnt_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign serve_entry = (state_d == ST_SERVE) && (state_q != ST_SERVE);

  serve_lfsr #(
    .ANGLE_W   (ANGLE_W),
    .LFSR_SEED (LFSR_SEED)
  ) u_serve_lfsr (
    .clk   (clk),
    .reset (reset),
    .load  (serve_entry),
    .theta (theta)
  );

  assign bus.ball_load = (state_q == ST_SERVE);
  assign bus.ball_en   = (state_q == ST_PLAY);
  assign bus.game_over = (state_q == ST_OVER);
  assign bus.state_o   = state_q;
  assign bus.theta_o   = theta;
  assign bus.serve_dir = dir_q;
  assign bus.score_l   = score_l_q;
  assign bus.score_r   = score_r_q;

endmodule
